// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: hold-FSM encoding and
// width helpers used to size the per-channel counters.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HELD_SHORT = 2'd1,
        ST_HELD_LONG  = 2'd2
    } hold_state_e;

    // Smallest width able to hold values up to (value - 1), never below 1 bit.
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            w = ((32'd1 << k) < value) ? (k + 1) : w;
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchroniser, debounce counter and a
// hold FSM that turns the debounced level into press/release/long/repeat pulses.
module button_channel
    import button_pkg::*;
#(
    parameter logic ACTIVE_LEVEL    = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   LONG_CYCLES     = 50000000,
    parameter int   REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button,
    output logic o_level,
    output logic o_pressed,
    output logic o_released,
    output logic o_long_press,
    output logic o_repeat
);

    localparam int DB_W   = clog2w(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = clog2w(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_TERM  = HOLD_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam bit                REPEAT_EN = (REPEAT_CYCLES > 0);
    localparam logic              INACTIVE  = ~ACTIVE_LEVEL;

    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_level;
    hold_state_e       r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_pressed;
    logic              r_released;
    logic              r_long_press;
    logic              r_repeat;

    logic w_s;
    logic w_toggle;
    logic w_rise;
    logic w_fall;

    // Toggle is the debounce terminal count; the hold FSM reacts on the same
    // edge so that level and the press/release pulse change together.
    assign w_s      = (r_sync2 == ACTIVE_LEVEL);
    assign w_toggle = (w_s != r_level) && (r_db_cnt == DB_TERM);
    assign w_rise   = w_toggle & ~r_level;
    assign w_fall   = w_toggle & r_level;

    // Two-flop synchroniser, parked at the inactive level during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= INACTIVE;
            r_sync2 <= INACTIVE;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after it persists DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= DB_ZERO;
            r_level  <= 1'b0;
        end else if (w_s == r_level) begin
            r_db_cnt <= DB_ZERO;
            r_level  <= r_level;
        end else if (w_toggle) begin
            r_db_cnt <= DB_ZERO;
            r_level  <= ~r_level;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
            r_level  <= r_level;
        end
    end

    // Hold FSM with registered event pulses; a fall overrides any hold event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= HOLD_ZERO;
            r_pressed    <= 1'b0;
            r_released   <= 1'b0;
            r_long_press <= 1'b0;
            r_repeat     <= 1'b0;
        end else begin
            r_pressed    <= 1'b0;
            r_released   <= 1'b0;
            r_long_press <= 1'b0;
            r_repeat     <= 1'b0;
            if (w_fall) begin
                r_state    <= ST_IDLE;
                r_released <= 1'b1;
                r_hold_cnt <= HOLD_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_hold_cnt <= HOLD_ZERO;
                        if (w_rise) begin
                            r_state   <= ST_HELD_SHORT;
                            r_pressed <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_HELD_SHORT: begin
                        if (r_hold_cnt == LONG_TERM) begin
                            r_state      <= ST_HELD_LONG;
                            r_long_press <= 1'b1;
                            r_hold_cnt   <= HOLD_ZERO;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    ST_HELD_LONG: begin
                        if (!REPEAT_EN) begin
                            r_hold_cnt <= HOLD_ZERO;
                        end else if (r_hold_cnt == REP_TERM) begin
                            r_repeat   <= 1'b1;
                            r_hold_cnt <= HOLD_ZERO;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_hold_cnt <= HOLD_ZERO;
                    end
                endcase
            end
        end
    end

    assign o_level      = r_level;
    assign o_pressed    = r_pressed;
    assign o_released   = r_released;
    assign o_long_press = r_long_press;
    assign o_repeat     = r_repeat;

endmodule

// File: rtl/button_events.sv
// Multi-channel push-button front end: one independent button_channel per pin,
// bit i of every output belonging to i_buttons[i].
module button_events
    import button_pkg::*;
#(
    parameter int   N_BUTTONS       = 4,
    parameter logic ACTIVE_LEVEL    = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   LONG_CYCLES     = 50000000,
    parameter int   REPEAT_CYCLES   = 10000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] i_buttons,
    output logic [N_BUTTONS-1:0] o_level,
    output logic [N_BUTTONS-1:0] o_pressed,
    output logic [N_BUTTONS-1:0] o_released,
    output logic [N_BUTTONS-1:0] o_long_press,
    output logic [N_BUTTONS-1:0] o_repeat
);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
        button_channel #(
            .ACTIVE_LEVEL    (ACTIVE_LEVEL),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_button     (i_buttons[g]),
            .o_level      (o_level[g]),
            .o_pressed    (o_pressed[g]),
            .o_released   (o_released[g]),
            .o_long_press (o_long_press[g]),
            .o_repeat     (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: two instances (repeat period 8 and repeat disabled)
// share one stimulus and are compared every cycle against an event model.
module tb_button_events;

    localparam int D  = 4;
    localparam int L  = 20;
    localparam int RA = 8;
    localparam int RB = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] buttons;

    logic [3:0] a_level, a_pr, a_rl, a_lp, a_rp;
    logic [3:0] b_level, b_pr, b_rl, b_lp, b_rp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_events #(.N_BUTTONS(4), .ACTIVE_LEVEL(1'b0), .DEBOUNCE_CYCLES(D),
                    .LONG_CYCLES(L), .REPEAT_CYCLES(RA)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_buttons(buttons),
        .o_level(a_level), .o_pressed(a_pr), .o_released(a_rl),
        .o_long_press(a_lp), .o_repeat(a_rp));

    button_events #(.N_BUTTONS(4), .ACTIVE_LEVEL(1'b0), .DEBOUNCE_CYCLES(D),
                    .LONG_CYCLES(L), .REPEAT_CYCLES(RB)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_buttons(buttons),
        .o_level(b_level), .o_pressed(b_pr), .o_released(b_rl),
        .o_long_press(b_lp), .o_repeat(b_rp));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Event model: pin delayed two samples, a streak of D differing samples
    // flips the level, and hold events follow from the age since the press.
    logic [3:0] m_s1, m_s2, m_level, m_pr, m_rl;
    logic [3:0] m_lp [2];
    logic [3:0] m_rp [2];
    int         m_run [4];
    int         m_age [2][4];

    function automatic int rep_of(input int i);
        return (i == 0) ? RA : RB;
    endfunction

    task automatic model_reset();
        m_s1 = 4'h0; m_s2 = 4'h0; m_level = 4'h0; m_pr = 4'h0; m_rl = 4'h0;
        for (int i = 0; i < 2; i++) begin
            m_lp[i] = 4'h0; m_rp[i] = 4'h0;
            for (int c = 0; c < 4; c++) m_age[i][c] = 0;
        end
        for (int c = 0; c < 4; c++) m_run[c] = 0;
    endtask

    task automatic model_step();
        logic use_s;
        bit   ev;
        for (int c = 0; c < 4; c++) begin
            use_s   = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = (buttons[c] == 1'b0);
            m_pr[c] = 1'b0;
            m_rl[c] = 1'b0;
            ev      = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_lp[i][c] = 1'b0;
                m_rp[i][c] = 1'b0;
            end
            if (use_s != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_run[c]   = 0;
                    m_level[c] = use_s;
                    ev         = 1'b1;
                    if (use_s) begin
                        m_pr[c] = 1'b1;
                        for (int i = 0; i < 2; i++) m_age[i][c] = 0;
                    end else begin
                        m_rl[c] = 1'b1;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
            if (!ev && m_level[c]) begin
                for (int i = 0; i < 2; i++) begin
                    m_age[i][c]++;
                    if (m_age[i][c] == L)
                        m_lp[i][c] = 1'b1;
                    else if (rep_of(i) > 0 && m_age[i][c] > L && ((m_age[i][c] - L) % rep_of(i)) == 0)
                        m_rp[i][c] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("dutA_vs_model", {12'h000, a_level, a_pr, a_rl, a_lp, a_rp},
                  {12'h000, m_level, m_pr, m_rl, m_lp[0], m_rp[0]});
            check("dutB_vs_model", {12'h000, b_level, b_pr, b_rl, b_lp, b_rp},
                  {12'h000, m_level, m_pr, m_rl, m_lp[1], m_rp[1]});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n   = 1'b0;
        buttons = 4'hF;
        model_reset();
        step(3);
        check("reset_outputs", {12'h000, a_level, a_pr, a_rl, a_lp, a_rp}, 32'h0);
        rst_n = 1'b1;
        step(4);

        // Clean press on channel 0: level and pressed exactly 6 cycles after the edge.
        buttons[0] = 1'b0;
        step(5);
        check("press0_early", a_level, 4'h0);
        step(1);
        check("press0_level", a_level, 4'h1);
        check("press0_pulse", a_pr, 4'h1);
        step(1);
        check("press0_single", a_pr, 4'h0);
        step(3);
        buttons[0] = 1'b1;
        step(6);
        check("release0", a_rl, 4'h1);
        step(4);

        // Bounce on channel 1 is rejected, then a solid press is accepted.
        buttons[1] = 1'b0; step(3);
        buttons[1] = 1'b1; step(1);
        buttons[1] = 1'b0; step(3);
        buttons[1] = 1'b1; step(10);
        check("bounce1_level", a_level, 4'h0);
        buttons[1] = 1'b0;
        step(6);
        check("bounce1_press", a_pr, 4'h2);
        step(2);
        buttons[1] = 1'b1;
        step(10);

        // Long press with repeat on channel 2.
        buttons[2] = 1'b0;
        step(6);
        check("long2_press", a_pr, 4'h4);
        step(19);
        check("long2_early", a_lp, 4'h0);
        step(1);
        check("long2_fire_a", a_lp, 4'h4);
        check("long2_fire_b", b_lp, 4'h4);
        step(8);
        check("rep2_first_a", a_rp, 4'h4);
        check("rep2_none_b", b_rp, 4'h0);
        step(25);
        buttons[2] = 1'b1;
        step(6);
        check("release2", a_rl, 4'h4);
        check("release2_norep", a_rp, 4'h0);
        step(4);

        // Short hold: level falls 15 cycles after the press, no long_press.
        buttons[0] = 1'b0;
        step(6);
        check("short0_press", a_pr, 4'h1);
        step(9);
        buttons[0] = 1'b1;
        step(6);
        check("short0_release", a_rl, 4'h1);
        check("short0_nolong", a_lp, 4'h0);
        step(4);

        // Reset while channel 3 is in the long-hold state, pin held through it.
        buttons[3] = 1'b0;
        step(29);
        check("hold3_level", a_level, 4'h8);
        rst_n = 1'b0;
        #1;
        check("rst_mid_a", {12'h000, a_level, a_pr, a_rl, a_lp, a_rp}, 32'h0);
        check("rst_mid_b", {12'h000, b_level, b_pr, b_rl, b_lp, b_rp}, 32'h0);
        step(3);
        rst_n = 1'b1;
        step(5);
        check("rst3_early", a_level, 4'h0);
        step(1);
        check("rst3_press", a_pr, 4'h8);
        buttons[3] = 1'b1;
        step(10);

        // All four channels pressed in the same cycle.
        buttons = 4'h0;
        step(6);
        check("multi_press_a", a_pr, 4'hF);
        check("multi_press_b", b_pr, 4'hF);
        buttons = 4'hF;
        step(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
